decode_seq: RTL and testbench

DECODE_SEQ -- requirements
Module: decode_seq

---
 rtl/decode_seq_pkg.sv | 27 ++
 rtl/decode_prefix_strip.sv | 27 ++
 rtl/decode_seq.sv | 179 +++++++++++++++++
 tb/tb_decode_seq.sv | 416 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_seq_pkg.sv
// Shared definitions for decode_seq: FSM encoding, prefix/escape byte constants, prefix limit.
// DECODE_SEQ_PREFIX_EN selects whether legacy prefix bytes are stripped.
package decode_seq_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPrefix,
      StEscape,
      StDecode,
      StOut
   } state_e;

   localparam logic [7:0] PfxOpsize = 8'h66;
   localparam logic [7:0] PfxRepne  = 8'hF2;
   localparam logic [7:0] PfxRep    = 8'hF3;
   localparam logic [7:0] PfxLock   = 8'hF0;
   localparam logic [7:0] EscByte   = 8'h0F;

   localparam logic [2:0] MaxPfxCnt = 3'd4;

`ifdef DECODE_SEQ_PREFIX_EN
   localparam bit PrefixEn = 1'b1;
`else
   localparam bit PrefixEn = 1'b0;
`endif

endpackage

// File: rtl/decode_prefix_strip.sv
// Stateless classifier for byte 0 of the window (prefix class, escape) plus the
// one-byte right-shifted window used when that byte is consumed.
module decode_prefix_strip
   import decode_seq_pkg::*;
(
   input  logic [71:0] win_i,
   output logic [3:0]  pfx_o,
   output logic        esc_o,
   output logic [71:0] shifted_o
);

   // Flag order {lock, rep, repne, opsize} matches out_pfx.
   always_comb begin
      pfx_o = 4'b0000;
      case (win_i[7:0])
         PfxLock:   pfx_o = 4'b1000;
         PfxRep:    pfx_o = 4'b0100;
         PfxRepne:  pfx_o = 4'b0010;
         PfxOpsize: pfx_o = 4'b0001;
         default:   pfx_o = 4'b0000;
      endcase
   end

   assign esc_o     = (win_i[7:0] == EscByte);
   assign shifted_o = {8'h00, win_i[71:8]};

endmodule

// File: rtl/decode_seq.sv
// Decode sequencer: strips prefixes and the 0x0F escape, presents the window to the opcode
// decoder and registers its result. DECODE_SEQ_PREFIX_EN enables prefix stripping.
module decode_seq
   import decode_seq_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [71:0] in_instr,
   output logic [71:0] dec_instr,
   output logic        dec_is_2byte,
   input  logic [6:0]  dec_opc,
   input  logic [3:0]  dec_opnd_form,
   input  logic        dec_imm_1byte,
   input  logic        dec_reg_1byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [6:0]  out_opc,
   output logic [3:0]  out_opnd_form,
   output logic        out_imm_1byte,
   output logic        out_reg_1byte,
   output logic        out_is_2byte,
   output logic [3:0]  out_pfx,
   output logic [2:0]  out_len
);

   state_e      state_q, state_d;
   logic [71:0] buf_q, buf_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [2:0]  len_q, len_d;
   logic [3:0]  pfx_q, pfx_d;
   logic        is2_q, is2_d;
   logic        hold_q, hold_d;
   logic        in_ready_q, in_ready_d;
   logic        out_valid_q, out_valid_d;
   logic [6:0]  opc_q, opc_d;
   logic [3:0]  form_q, form_d;
   logic        imm_q, imm_d;
   logic        reg_q, reg_d;

   logic [3:0]  pfx_hit;
   logic        esc_hit;
   logic [71:0] buf_shift;

   decode_prefix_strip u_strip (
      .win_i     (buf_q),
      .pfx_o     (pfx_hit),
      .esc_o     (esc_hit),
      .shifted_o (buf_shift)
   );

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      pfx_d       = pfx_q;
      is2_d       = is2_q;
      hold_d      = hold_q;
      out_valid_d = out_valid_q;
      opc_d       = opc_q;
      form_d      = form_q;
      imm_d       = imm_q;
      reg_d       = reg_q;

      if (flush) begin
         state_d     = StIdle;
         buf_d       = '0;
         hold_d      = 1'b0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid && in_ready_q) begin
                  buf_d   = in_instr;
                  cnt_d   = 3'd0;
                  len_d   = 3'd0;
                  pfx_d   = 4'b0000;
                  is2_d   = 1'b0;
                  state_d = PrefixEn ? StPrefix : StEscape;
                  // Without prefix stripping, one idle ESCAPE cycle keeps latency at 3.
                  hold_d  = ~PrefixEn;
               end
            end
            StPrefix: begin
               if ((pfx_hit != 4'b0000) && (cnt_q < MaxPfxCnt)) begin
                  buf_d = buf_shift;
                  pfx_d = pfx_q | pfx_hit;
                  cnt_d = cnt_q + 3'd1;
                  len_d = len_q + 3'd1;
               end else begin
                  state_d = StEscape;
               end
            end
            StEscape: begin
               if (hold_q) begin
                  hold_d = 1'b0;
               end else begin
                  if (esc_hit) begin
                     buf_d = buf_shift;
                     is2_d = 1'b1;
                     len_d = len_q + 3'd1;
                  end
                  state_d = StDecode;
               end
            end
            StDecode: begin
               opc_d       = dec_opc;
               form_d      = dec_opnd_form;
               imm_d       = dec_imm_1byte;
               reg_d       = dec_reg_1byte;
               out_valid_d = 1'b1;
               state_d     = StOut;
            end
            StOut: begin
               if (out_ready) begin
                  out_valid_d = 1'b0;
                  state_d     = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end

      in_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         buf_q       <= '0;
         cnt_q       <= 3'd0;
         len_q       <= 3'd0;
         pfx_q       <= 4'b0000;
         is2_q       <= 1'b0;
         hold_q      <= 1'b0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         opc_q       <= '0;
         form_q      <= '0;
         imm_q       <= 1'b0;
         reg_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         pfx_q       <= pfx_d;
         is2_q       <= is2_d;
         hold_q      <= hold_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         opc_q       <= opc_d;
         form_q      <= form_d;
         imm_q       <= imm_d;
         reg_q       <= reg_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign dec_instr     = buf_q;
   assign dec_is_2byte  = is2_q;
   assign out_valid     = out_valid_q;
   assign out_opc       = opc_q;
   assign out_opnd_form = form_q;
   assign out_imm_1byte = imm_q;
   assign out_reg_1byte = reg_q;
   assign out_is_2byte  = is2_q;
   assign out_len       = len_q;

`ifdef DECODE_SEQ_PREFIX_EN
   assign out_pfx = pfx_q;
`else
   assign out_pfx = 4'b0000;
`endif

endmodule

// File: tb/tb_decode_seq.sv
// Self-checking bench for decode_seq; expectations adapt to DECODE_SEQ_PREFIX_EN.
module tb_decode_seq;

   typedef struct packed {
      logic [7:0] b0;
      logic [6:0] opc;
      logic [3:0] form;
      logic       imm;
      logic       rg;
      logic       is2;
      logic [3:0] pfx;
      logic [2:0] len;
      logic [7:0] lat;
   } res_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [71:0] in_instr = '0;
   logic [71:0] dec_instr;
   logic        dec_is_2byte;
   logic [6:0]  dec_opc;
   logic [3:0]  dec_opnd_form;
   logic        dec_imm_1byte;
   logic        dec_reg_1byte;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [6:0]  out_opc;
   logic [3:0]  out_opnd_form;
   logic        out_imm_1byte;
   logic        out_reg_1byte;
   logic        out_is_2byte;
   logic [3:0]  out_pfx;
   logic [2:0]  out_len;

   decode_seq dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .flush         (flush),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .dec_instr     (dec_instr),
      .dec_is_2byte  (dec_is_2byte),
      .dec_opc       (dec_opc),
      .dec_opnd_form (dec_opnd_form),
      .dec_imm_1byte (dec_imm_1byte),
      .dec_reg_1byte (dec_reg_1byte),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_opc       (out_opc),
      .out_opnd_form (out_opnd_form),
      .out_imm_1byte (out_imm_1byte),
      .out_reg_1byte (out_reg_1byte),
      .out_is_2byte  (out_is_2byte),
      .out_pfx       (out_pfx),
      .out_len       (out_len)
   );

   // Toy phase-2 decoder so the registered results depend on the stripped window.
   assign dec_opc       = dec_instr[6:0];
   assign dec_opnd_form = dec_instr[11:8];
   assign dec_imm_1byte = dec_instr[15];
   assign dec_reg_1byte = dec_instr[7] ^ dec_is_2byte;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_checks = 0;
   int   n_pass = 0;
   int   acc_cyc = 0;
   res_t exp_q[$];

   function automatic res_t model(input logic [71:0] w);
      res_t        e;
      logic [71:0] b;
      int          np;
      e  = '0;
      b  = w;
      np = 0;
`ifdef DECODE_SEQ_PREFIX_EN
      while (np < 4 && (b[7:0] == 8'h66 || b[7:0] == 8'hF2 || b[7:0] == 8'hF3 ||
                        b[7:0] == 8'hF0)) begin
         case (b[7:0])
            8'hF0:   e.pfx[3] = 1'b1;
            8'hF3:   e.pfx[2] = 1'b1;
            8'hF2:   e.pfx[1] = 1'b1;
            default: e.pfx[0] = 1'b1;
         endcase
         b  = b >> 8;
         np = np + 1;
      end
`endif
      e.len = 3'(np);
      if (b[7:0] == 8'h0F) begin
         b     = b >> 8;
         e.is2 = 1'b1;
         e.len = e.len + 3'd1;
      end
      e.b0   = b[7:0];
      e.opc  = b[6:0];
      e.form = b[11:8];
      e.imm  = b[15];
      e.rg   = b[7] ^ e.is2;
      e.lat  = 8'(3 + np);
      return e;
   endfunction

   task automatic drive(input logic [71:0] w, input bit push);
      for (int i = 0; i < 50 && !in_ready; i++) begin
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL drive_ready: in_ready=%b required 1", in_ready);
      else n_pass++;
      in_valid = 1'b1;
      in_instr = w;
      @(posedge clk);
      #1;
      acc_cyc  = cyc;
      in_valid = 1'b0;
      in_instr = {$urandom, $urandom, 8'($urandom)};
      if (push) exp_q.push_back(model(w));
   endtask

   task automatic collect(output res_t o, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
      end
      o.b0   = dec_instr[7:0];
      o.opc  = out_opc;
      o.form = out_opnd_form;
      o.imm  = out_imm_1byte;
      o.rg   = out_reg_1byte;
      o.is2  = out_is_2byte;
      o.pfx  = out_pfx;
      o.len  = out_len;
      o.lat  = 8'(cyc - acc_cyc);
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, dec_is_2byte, out_pfx, out_len, out_is_2byte} !== '0 ||
          dec_instr !== '0 || out_opc !== '0)
         $display("FAIL reset_state: in_ready=%b out_valid=%b dec_instr=%h required all 0",
                  in_ready, out_valid, dec_instr);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      n_checks++;
      if (in_ready !== 1'b0) $display("FAIL reset_ready_early: in_ready=%b required 0", in_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL reset_ready_rise: in_ready=%b required 1", in_ready);
      else n_pass++;
   endtask

   task automatic test_basic();
      res_t o, e;
      bit   ok;
      out_ready = 1'b1;
      drive({64'h1234_5678_9ABC_DE22, 8'h01}, 1'b1);
      collect(o, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || o !== e) $display("FAIL basic_result: got %h required %h", o, e);
      else n_pass++;
      n_checks++;
      if (o.lat !== 8'd3 || o.len !== 3'd0 || o.is2 !== 1'b0 || o.pfx !== 4'b0000)
         $display("FAIL basic_fields: lat=%0d len=%0d is2=%b pfx=%b required 3 0 0 0000",
                  o.lat, o.len, o.is2, o.pfx);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL basic_handshake: out_valid=%b in_ready=%b required 0 1",
                  out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic test_prefix_escape();
      res_t o, e;
      bit   ok;
      logic [7:0] x_b0;
      logic       x_is2;
      logic [3:0] x_pfx;
      logic [2:0] x_len;
      logic [7:0] x_lat;
`ifdef DECODE_SEQ_PREFIX_EN
      x_b0 = 8'hAF; x_is2 = 1'b1; x_pfx = 4'b0001; x_len = 3'd2; x_lat = 8'd4;
`else
      x_b0 = 8'h66; x_is2 = 1'b0; x_pfx = 4'b0000; x_len = 3'd0; x_lat = 8'd3;
`endif
      drive({48'h0000_1122_3344, 8'hAF, 8'h0F, 8'h66}, 1'b1);
      collect(o, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || o !== e) $display("FAIL pfx_esc_result: got %h required %h", o, e);
      else n_pass++;
      n_checks++;
      if (o.b0 !== x_b0 || o.is2 !== x_is2 || o.pfx !== x_pfx || o.len !== x_len ||
          o.lat !== x_lat)
         $display("FAIL pfx_esc_fields: b0=%h is2=%b pfx=%b len=%0d lat=%0d required %h %b %b %0d %0d",
                  o.b0, o.is2, o.pfx, o.len, o.lat, x_b0, x_is2, x_pfx, x_len, x_lat);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_rep_max();
      res_t o, e;
      bit   ok;
      logic [2:0] x_len;
      logic [3:0] x_pfx;
`ifdef DECODE_SEQ_PREFIX_EN
      x_len = 3'd4; x_pfx = 4'b0100;
`else
      x_len = 3'd0; x_pfx = 4'b0000;
`endif
      drive({24'h00_0000, 8'h90, {5{8'hF3}}}, 1'b1);
      collect(o, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || o !== e) $display("FAIL rep_max_result: got %h required %h", o, e);
      else n_pass++;
      n_checks++;
      if (o.b0 !== 8'hF3 || o.len !== x_len || o.pfx !== x_pfx)
         $display("FAIL rep_max_fields: b0=%h len=%0d pfx=%b required F3 %0d %b",
                  o.b0, o.len, o.pfx, x_len, x_pfx);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_backpressure();
      res_t        o, e;
      bit          ok;
      logic [92:0] snap, cur;
      int          bad;
      out_ready = 1'b0;
      drive({48'hAAAA_5555_0F0F, 8'h8C, 8'h0F, 8'hF2}, 1'b1);
      collect(o, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || o !== e) $display("FAIL bp_result: got %h required %h", o, e);
      else n_pass++;
      snap = {dec_instr, out_opc, out_opnd_form, out_imm_1byte, out_reg_1byte, out_is_2byte,
              out_pfx, out_len};
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         cur = {dec_instr, out_opc, out_opnd_form, out_imm_1byte, out_reg_1byte, out_is_2byte,
                out_pfx, out_len};
         n_checks++;
         if (cur !== snap || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            $display("FAIL bp_hold: cycle %0d valid=%b ready=%b out=%h required 1 0 %h",
                     i, out_valid, in_ready, cur, snap);
            bad++;
         end else n_pass++;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL bp_release: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      else n_pass++;
   endtask

   task automatic watch_quiet(input string name);
      bit seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0) seen = 1'b1;
      end
      n_checks++;
      if (seen) $display("FAIL %s_no_output: out_valid seen=1 required 0", name);
      else n_pass++;
   endtask

   task automatic test_flush();
      res_t o, e;
      bit   ok;
      // Flush right after accept (PREFIX with stripping, ESCAPE without).
      out_ready = 1'b1;
      drive({40'h0, 8'h01, 8'h66, 8'h66, 8'h66}, 1'b0);
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush_early: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      else n_pass++;
      watch_quiet("flush_early");
      // Flush together with out_ready while in OUT.
      out_ready = 1'b0;
      drive({56'h0, 8'h33, 8'h02}, 1'b1);
      collect(o, ok);
      e = exp_q.pop_front();
      n_checks++;
      if (!ok || o !== e) $display("FAIL flush_out_result: got %h required %h", o, e);
      else n_pass++;
      flush = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL flush_out: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
      else n_pass++;
      // Flush beats a simultaneous accept in IDLE.
      in_valid = 1'b1;
      in_instr = {64'h0, 8'h05};
      flush = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush = 1'b0;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL flush_accept: in_ready=%b required 1", in_ready);
      else n_pass++;
      watch_quiet("flush_accept");
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b1;
      drive({56'h0, 8'h44, 8'h01}, 1'b0);
`ifdef DECODE_SEQ_PREFIX_EN
      @(posedge clk);
      #1;
`endif
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({in_ready, out_valid, dec_is_2byte, out_pfx, out_len, out_is_2byte} !== '0 ||
          dec_instr !== '0 || out_opc !== '0)
         $display("FAIL mid_reset_state: in_ready=%b out_valid=%b dec_instr=%h required all 0",
                  in_ready, out_valid, dec_instr);
      else n_pass++;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL mid_reset_ready: in_ready=%b required 1", in_ready);
      else n_pass++;
      watch_quiet("mid_reset");
   endtask

   task automatic test_back_to_back();
      res_t        o, e;
      bit          ok;
      logic [71:0] w;
      logic [7:0]  by;
      out_ready = 1'b1;
      for (int t = 0; t < 10; t++) begin
         for (int k = 0; k < 9; k++) begin
            case ($urandom_range(0, 7))
               0:       by = 8'h66;
               1:       by = 8'hF2;
               2:       by = 8'hF3;
               3:       by = 8'hF0;
               4:       by = 8'h0F;
               default: by = 8'($urandom);
            endcase
            w[k*8 +: 8] = by;
         end
         drive(w, 1'b1);
         collect(o, ok);
         e = exp_q.pop_front();
         n_checks++;
         if (!ok || o !== e) $display("FAIL b2b_%0d: window %h got %h required %h", t, w, o, e);
         else n_pass++;
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_prefix_escape();
      test_rep_max();
      test_backpressure();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
